// File: rtl/arb_regfile_pkg.sv
// Shared defaults and width helpers for the multi-writer register bank
// and the round-robin arbiter it uses.
package arb_regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NWR   = 2;

    // Index width that stays at least one bit wide even for a single source.
    function automatic int sw_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, the pointer moves to
// just past the last winner so that winner drops to lowest priority.
module rr_arbiter
    import arb_regfile_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = sw_bits(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  upper_req;
    logic [PW-1:0] sel;
    logic          any_upper;

    // Requests at or above the pointer win first; otherwise wrap to the bottom.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign upper_req[gi] = req[gi] & (PW'(gi) >= ptr_q);
        end
    endgenerate

    always_comb begin
        sel       = '0;
        any_upper = |upper_req;
        grant     = '0;
        ptr_d     = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (any_upper ? upper_req[i] : req[i]) begin
                sel = PW'(i);
            end
        end
        if (!reset && (|req)) begin
            grant[sel] = 1'b1;
            ptr_d      = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_regfile.sv
// Multi-writer register bank: NWR arbitrated write ports into DEPTH entries,
// one registered read port returning data and the tag of the last writer.
module arb_regfile
    import arb_regfile_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = sw_bits(NWR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    output logic [NWR-1:0]       wr_grant,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic [SW-1:0]        rd_src,
    output logic                 rd_valid
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    logic [WIDTH-1:0] mem_view [DEPTH];
    logic [SW-1:0]    tag_view [DEPTH];

    logic [SW-1:0]    wr_src;
    logic [AW-1:0]    wr_sel_addr;
    logic [WIDTH-1:0] wr_sel_data;
    logic             wr_commit;

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [SW-1:0]    rd_src_q, rd_src_d;
    logic             rd_valid_q, rd_valid_d;

    rr_arbiter #(
        .N(NWR)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_en),
        .grant (wr_grant)
    );

    // Write mux steered by the one-hot grant; out-of-range winners commit nothing.
    always_comb begin
        wr_src      = '0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_grant[p]) begin
                wr_src      = SW'(p);
                wr_sel_addr = wr_addr[p*AW +: AW];
                wr_sel_data = wr_data[p*WIDTH +: WIDTH];
            end
        end
        wr_commit = (|wr_grant) && in_range(wr_sel_addr);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] mem_q, mem_d;
            logic [SW-1:0]    tag_q, tag_d;

            always_comb begin
                mem_d = mem_q;
                tag_d = tag_q;
                if (wr_commit && (wr_sel_addr == AW'(gi))) begin
                    mem_d = wr_sel_data;
                    tag_d = wr_src;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q <= '0;
                    tag_q <= '0;
                end else begin
                    mem_q <= mem_d;
                    tag_q <= tag_d;
                end
            end

            assign mem_view[gi] = mem_q;
            assign tag_view[gi] = tag_q;
        end
    endgenerate

    // Same-cycle write to the read address is forwarded into the read register.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_src_d   = rd_src_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            if (wr_commit && (wr_sel_addr == rd_addr)) begin
                rd_data_d = wr_sel_data;
                rd_src_d  = wr_src;
            end else if (in_range(rd_addr)) begin
                rd_data_d = mem_view[rd_addr];
                rd_src_d  = tag_view[rd_addr];
            end else begin
                rd_data_d = '0;
                rd_src_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_src_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_src_q   <= rd_src_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_src   = rd_src_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_arb_regfile.sv
// Two configurations (2 ports x 8 entries, 4 ports x 6 entries) driven by
// directed and random stimulus, checked against a queue-based reference model.
module tb_arb_regfile;

    localparam int W  = 16;
    localparam int AW = 3;
    localparam int NA = 2;
    localparam int DA = 8;
    localparam int NB = 4;
    localparam int DB = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NA-1:0]    a_wr_en, a_wr_grant;
    logic [NA*AW-1:0] a_wr_addr;
    logic [NA*W-1:0]  a_wr_data;
    logic             a_rd_en, a_rd_valid;
    logic [AW-1:0]    a_rd_addr;
    logic [W-1:0]     a_rd_data;
    logic [0:0]       a_rd_src;

    logic [NB-1:0]    b_wr_en, b_wr_grant;
    logic [NB*AW-1:0] b_wr_addr;
    logic [NB*W-1:0]  b_wr_data;
    logic             b_rd_en, b_rd_valid;
    logic [AW-1:0]    b_rd_addr;
    logic [W-1:0]     b_rd_data;
    logic [1:0]       b_rd_src;

    arb_regfile #(.WIDTH(W), .DEPTH(DA), .NWR(NA)) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_grant(a_wr_grant),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_src(a_rd_src), .rd_valid(a_rd_valid)
    );

    arb_regfile #(.WIDTH(W), .DEPTH(DB), .NWR(NB)) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_grant(b_wr_grant),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_src(b_rd_src), .rd_valid(b_rd_valid)
    );

    // Per-instance stimulus (index 0 = A, 1 = B), packed onto the DUT buses.
    logic          en_s      [2][4];
    logic [AW-1:0] addr_s    [2][4];
    logic [W-1:0]  data_s    [2][4];
    logic          rd_en_s   [2];
    logic [AW-1:0] rd_addr_s [2];

    always_comb begin
        a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        for (int p = 0; p < NA; p++) begin
            a_wr_en[p]          = en_s[0][p];
            a_wr_addr[p*AW +: AW] = addr_s[0][p];
            a_wr_data[p*W +: W]   = data_s[0][p];
        end
        for (int p = 0; p < NB; p++) begin
            b_wr_en[p]          = en_s[1][p];
            b_wr_addr[p*AW +: AW] = addr_s[1][p];
            b_wr_data[p*W +: W]   = data_s[1][p];
        end
        a_rd_en   = rd_en_s[0];
        a_rd_addr = rd_addr_s[0];
        b_rd_en   = rd_en_s[1];
        b_rd_addr = rd_addr_s[1];
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   s;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int ptr_m [2];
    logic [W-1:0] mem_m [2][8];
    int tag_m [2][8];
    int last_g [2];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    function automatic int nports(input int i);
        return (i == 0) ? NA : NB;
    endfunction

    function automatic int ndepth(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    // Scan ptr, ptr+1, ... modulo the port count for the first requester.
    function automatic int model_grant(input int i);
        for (int k = 0; k < nports(i); k++) begin
            int idx;
            idx = (ptr_m[i] + k) % nports(i);
            if (en_s[i][idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] grant_vec(input int i);
        return (i == 0) ? 32'(a_wr_grant) : 32'(b_wr_grant);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ptr_m[i] = 0;
            for (int a = 0; a < 8; a++) begin
                mem_m[i][a] = '0;
                tag_m[i][a] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 4; p++) begin
                en_s[i][p]   = 1'b0;
                addr_s[i][p] = '0;
                data_s[i][p] = '0;
            end
            rd_en_s[i]   = 1'b0;
            rd_addr_s[i] = '0;
        end
    endtask

    task automatic set_wr(input int i, input int p, input logic e, input int a, input logic [W-1:0] d);
        en_s[i][p]   = e;
        addr_s[i][p] = AW'(a);
        data_s[i][p] = d;
    endtask

    task automatic set_rd(input int i, input logic e, input int a);
        rd_en_s[i]   = e;
        rd_addr_s[i] = AW'(a);
    endtask

    // One clock: check grants, predict reads, then advance the model at the edge.
    task automatic step();
        int   g [2];
        exp_t e [2];
        bit   rd [2];
        int   ra;
        int   wa;
        #1;
        for (int i = 0; i < 2; i++) begin
            g[i] = reset ? -1 : model_grant(i);
            chk($sformatf("grant%0d", i), grant_vec(i), (g[i] < 0) ? 32'd0 : (32'd1 << g[i]));
            rd[i] = !reset && rd_en_s[i];
            ra    = int'(rd_addr_s[i]);
            e[i]  = '0;
            if (g[i] >= 0 && int'(addr_s[i][g[i]]) == ra && ra < ndepth(i)) begin
                e[i].d = data_s[i][g[i]];
                e[i].s = 2'(g[i]);
            end else if (ra < ndepth(i)) begin
                e[i].d = mem_m[i][ra];
                e[i].s = 2'(tag_m[i][ra]);
            end
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rd[i]) begin
                    if (i == 0) qa.push_back(e[i]);
                    else        qb.push_back(e[i]);
                end
                if (g[i] >= 0) begin
                    wa = int'(addr_s[i][g[i]]);
                    if (wa < ndepth(i)) begin
                        mem_m[i][wa] = data_s[i][g[i]];
                        tag_m[i][wa] = g[i];
                    end
                    ptr_m[i] = (g[i] + 1) % nports(i);
                end
            end
        end
        for (int i = 0; i < 2; i++) last_g[i] = g[i];
        @(negedge clk);
    endtask

    task automatic mon(input int i);
        logic         v;
        logic [W-1:0] d;
        logic [1:0]   s;
        exp_t         e;
        bit           have;
        have = 1'b0;
        e    = '0;
        if (i == 0) begin
            v = a_rd_valid; d = a_rd_data; s = {1'b0, a_rd_src};
            if (qa.size() > 0) begin have = 1'b1; e = qa.pop_front(); end
        end else begin
            v = b_rd_valid; d = b_rd_data; s = b_rd_src;
            if (qb.size() > 0) begin have = 1'b1; e = qb.pop_front(); end
        end
        if (have) begin
            chk($sformatf("rd_valid%0d", i), 32'(v), 32'd1);
            chk($sformatf("rd_data%0d", i), 32'(d), 32'(e.d));
            chk($sformatf("rd_src%0d", i), 32'(s), 32'(e.s));
            $display("read inst%0d data=%h src=%0d (expected %h/%0d)", i, d, s, e.d, e.s);
        end else begin
            chk($sformatf("rd_valid_idle%0d", i), 32'(v), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        int order [6];
        bit found;
        order = '{0, 2, 3, 0, 2, 3};
        for (int i = 0; i < 2; i++) last_g[i] = -1;
        model_reset();
        clear_inputs();

        // Reset with every port requesting: grants must stay low.
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            set_wr(0, p, 1'b1, p, 16'h1234);
            set_wr(1, p, 1'b1, p, 16'h4321);
        end
        step();
        step();
        mon_en = 1'b1;
        reset  = 1'b0;
        clear_inputs();

        // Idle read after reset.
        set_rd(0, 1'b1, 3);
        step();
        chk("reset_rd_data", 32'(a_rd_data), 32'd0);
        chk("reset_rd_src", 32'(a_rd_src), 32'd0);
        chk("reset_rd_valid", 32'(a_rd_valid), 32'd1);
        clear_inputs();

        // Two-port contention on addr1, reading it back every cycle.
        set_wr(0, 0, 1'b1, 1, 16'h0001);
        set_wr(0, 1, 1'b1, 1, 16'h269A);
        set_rd(0, 1'b1, 1);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("contention_grant", 32'(a_wr_grant), (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
        end
        chk("contention_last_data", 32'(a_rd_data), 32'h269A);
        chk("contention_last_src", 32'(a_rd_src), 32'd1);
        clear_inputs();

        // Same-cycle write/read bypass.
        set_wr(0, 1, 1'b1, 5, 16'h6FA7);
        set_rd(0, 1'b1, 5);
        step();
        chk("bypass_data", 32'(a_rd_data), 32'h6FA7);
        chk("bypass_src", 32'(a_rd_src), 32'd1);
        clear_inputs();

        // Four-port fairness from a freshly reset pointer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_wr(1, 0, 1'b1, 0, 16'hA000);
        set_wr(1, 2, 1'b1, 2, 16'hA002);
        set_wr(1, 3, 1'b1, 3, 16'hA003);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fairness_order", 32'(b_wr_grant), 32'd1 << order[k]);
            step();
        end
        set_wr(1, 1, 1'b1, 1, 16'hA001);
        found = 1'b0;
        for (int k = 0; k < NB && !found; k++) begin
            #1;
            if (b_wr_grant[1]) found = 1'b1;
            step();
        end
        chk("fairness_port1_within_nwr", 32'(found), 32'd1);
        clear_inputs();

        // Out-of-range write still advances the pointer; out-of-range read returns zero.
        set_wr(1, 2, 1'b1, 7, 16'hBEEF);
        step();
        set_wr(1, 2, 1'b1, 0, 16'h1111);
        set_wr(1, 3, 1'b1, 0, 16'h2222);
        #1;
        chk("oor_ptr_advance", 32'(b_wr_grant), 32'd8);
        step();
        set_wr(1, 3, 1'b0, 0, 16'h0000);
        step();
        clear_inputs();
        set_rd(1, 1'b1, 7);
        step();
        chk("oor_rd_data", 32'(b_rd_data), 32'd0);
        chk("oor_rd_valid", 32'(b_rd_valid), 32'd1);
        for (int a = 0; a < DB; a++) begin
            set_rd(1, 1'b1, a);
            step();
        end
        clear_inputs();

        // Reset asserted while both ports contend, with the pointer parked at 1.
        set_wr(0, 0, 1'b1, 2, 16'hAAAA);
        step();
        set_wr(0, 0, 1'b1, 2, 16'hAAAA);
        set_wr(0, 1, 1'b1, 2, 16'h5555);
        reset = 1'b1;
        #1;
        chk("reset_contention_grant", 32'(a_wr_grant), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("post_reset_grant", 32'(a_wr_grant), 32'd1);
        step();
        clear_inputs();
        set_rd(0, 1'b1, 2);
        step();
        clear_inputs();

        // Random traffic; an ungranted requester keeps its request unchanged.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < nports(i); p++) begin
                    if (!(en_s[i][p] && last_g[i] != p)) begin
                        set_wr(i, p, ($urandom_range(0, 99) < 50), int'($urandom_range(0, 7)), W'($urandom));
                    end
                end
                set_rd(i, ($urandom_range(0, 99) < 70), int'($urandom_range(0, 7)));
            end
            step();
        end

        reset = 1'b0;
        clear_inputs();
        step();
        step();
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
